// File: rtl/march_bist_controller.sv
// March C- sequencer for the memory BIST datapath. It steps an external
// up-counting address generator and derives descending addresses by
// inverting the count. It issues RAM reads and writes and checks read data
// against the expected background. It reports busy/done and keeps a sticky
// record of the first failure.
module march_bist_controller #(
   parameter int ARRAY_SIZE = 16,
   parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic                  ag_rst,
   output logic                  ag_en,
   input  logic [ADDR_WIDTH-1:0] ag_addr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ARRAY_SIZE - 1);

   state_t                state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  done_q, done_d;
   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]            fail_elem_q, fail_elem_d;

   logic                  down_elem;
   logic                  wr_ones;
   logic                  rd_ones;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] rd_bg;

   // M3 and M4 walk downwards. M1 and M3 write ones. M2 and M4 expect ones back.
   assign down_elem = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign wr_ones   = (elem_q == 3'd1) || (elem_q == 3'd3);
   assign rd_ones   = (elem_q == 3'd2) || (elem_q == 3'd4);
   assign cur_addr  = down_elem ? ~ag_addr : ag_addr;
   assign rd_bg     = rd_ones ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};

   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;

   // Next-state, status update and combinational RAM/address-generator controls
   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      busy        = 1'b0;
      ag_rst      = 1'b0;
      ag_en       = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_wdata   = '0;
      unique case (state_q)
         S_IDLE: begin
            ag_rst = 1'b1;
            if (start) begin
               done_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = '0;
               elem_d      = 3'd0;
               state_d     = S_WR;
            end
         end
         S_RD: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = cur_addr;
            state_d  = S_WR;
         end
         S_WR: begin
            busy      = 1'b1;
            ag_en     = 1'b1;
            mem_addr  = cur_addr;
            mem_we    = (elem_q != 3'd5);
            mem_wdata = wr_ones ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
            // Read data from the preceding RD lands exactly in this cycle
            if ((elem_q != 3'd0) && (mem_rdata != rd_bg)) begin
               fail_d = 1'b1;
               if (!fail_q) begin
                  fail_addr_d = cur_addr;
                  fail_elem_d = elem_q;
               end
            end
            // The generator wraps to 0 on its own after the last word
            if (ag_addr == LAST_ADDR) begin
               if (elem_q == 3'd5) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  elem_d  = elem_q + 3'd1;
                  state_d = S_RD;
               end
            end else if (elem_q != 3'd0) begin
               state_d = S_RD;
            end
         end
         S_DONE: begin
            ag_rst  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and sticky status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         elem_q      <= '0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

endmodule

// File: tb/tb_march_bist_controller.sv
// Bench for march_bist_controller. It provides the address generator and a
// RAM with an optional stuck-at-0 on bit 0 of word 5. An algorithmic March C-
// model supplies the expected outputs for every cycle of a pass.
module tb_march_bist_controller;

   localparam int N  = 16;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic          ag_rst, ag_en;
   logic [AW-1:0] ag_addr = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_we, mem_re;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] ram [N];
   bit            fault_en = 1'b0;

   march_bist_controller #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem),
      .ag_rst(ag_rst), .ag_en(ag_en), .ag_addr(ag_addr),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Address generator: up counter with synchronous reset and enable
   always @(posedge clk) begin
      if (rst || ag_rst) ag_addr <= '0;
      else if (ag_en)    ag_addr <= ag_addr + 1'b1;
   end

   // Single-port RAM, 1-cycle read latency, optional stuck-at-0 fault
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= (fault_en && mem_addr == 4'd5) ? (mem_wdata & 8'hFE) : mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   typedef struct packed {
      logic          busy, done, fail;
      logic [AW-1:0] faddr;
      logic [2:0]    felem;
      logic          we, re;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          ag_en, ag_rst;
   } exp_t;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } lit_t;

   exp_t exp_q[$];
   lit_t lit_q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic string fmt(exp_t v);
      return $sformatf("busy=%b done=%b fail=%b faddr=%0d felem=%0d we=%b re=%b addr=%0d wdata=%h ag_en=%b ag_rst=%b",
                       v.busy, v.done, v.fail, v.faddr, v.felem, v.we, v.re, v.addr, v.wdata, v.ag_en, v.ag_rst);
   endfunction

   // Single compare process: literal checks first, then the per-cycle model entry
   always @(negedge clk) begin
      exp_t e, a;
      lit_t l;
      a = '{busy, done, fail, fail_addr, fail_elem, mem_we, mem_re, mem_addr, mem_wdata, ag_en, ag_rst};
      while (lit_q.size() > 0) begin
         l = lit_q.pop_front();
         n_tot++;
         if (l.act == l.exp) n_pass++;
         else $display("FAIL %s: got %0d, expected %0d", l.name, l.act, l.exp);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tot++;
         if (a === e) n_pass++;
         else $display("FAIL cycle_outputs @%0t: got {%s} expected {%s}", $time, fmt(a), fmt(e));
      end
   end

   // Activity monitor: counts per pass, cycle index relative to the accepted start
   int cyc_n = 0, s0 = 0, c = 0;
   int nwr = 0, nrd = 0, nwr0 = 0, done_cyc = 0;
   int addr_log [0:255];
   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      if (start && !busy) begin
         s0 = cyc_n; nwr = 0; nrd = 0; nwr0 = 0; done_cyc = 0;
      end else begin
         c = cyc_n - s0;
         if (mem_we) begin nwr++; if (c <= 16) nwr0++; end
         if (mem_re) nrd++;
         if (done && done_cyc == 0) done_cyc = c;
         if (c >= 0 && c < 256) addr_log[c] = int'(mem_addr);
      end
   end

   task automatic lit(input string n, input int a, input int x);
      lit_t l;
      l.name = n; l.act = a; l.exp = x;
      lit_q.push_back(l);
   endtask

   task automatic push_idle(input bit d, input bit f, input int fa, input int fe);
      exp_t v;
      v = '0;
      v.done = d; v.fail = f; v.faddr = AW'(fa); v.felem = 3'(fe); v.ag_rst = 1'b1;
      exp_q.push_back(v);
   endtask

   // March C- model: walks the elements over an ideal (optionally faulty) array
   task automatic build(input bit f);
      logic [DW-1:0] m [N];
      logic [DW-1:0] wb, rb;
      exp_t v;
      bit sf, mis;
      int sa, se, a;
      sf = 0; sa = 0; se = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a   = (e == 3 || e == 4) ? N - 1 - i : i;
            wb  = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            rb  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            mis = 0;
            if (e > 0) begin
               v = '0;
               v.busy = 1; v.fail = sf; v.faddr = AW'(sa); v.felem = 3'(se);
               v.re = 1; v.addr = AW'(a);
               exp_q.push_back(v);
               mis = (m[a] !== rb);
            end
            v = '0;
            v.busy = 1; v.fail = sf; v.faddr = AW'(sa); v.felem = 3'(se);
            v.we = (e != 5); v.wdata = (e != 5) ? wb : 8'h00; v.addr = AW'(a); v.ag_en = 1;
            exp_q.push_back(v);
            if (e != 5) m[a] = (f && a == 5) ? (wb & 8'hFE) : wb;
            if (mis && !sf) begin sa = a; se = e; end
            if (mis) sf = 1;
         end
      end
      push_idle(1, sf, sa, se);
      push_idle(1, sf, sa, se);
   endtask

   task automatic launch(input bit f);
      @(posedge clk); #1;
      fault_en = f;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      build(f);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state while rst is held
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_idle(0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fault-free pass
      launch(0);
      wait_cycles(180);
      lit("done_cycle", done_cyc, 177);
      lit("write_count", nwr, 80);
      lit("read_count", nrd, 80);
      lit("m0_write_count", nwr0, 16);
      lit("m1_first_rd_addr", addr_log[17], 0);
      lit("m1_second_rd_addr", addr_log[19], 1);
      lit("m3_first_rd_addr", addr_log[81], 15);
      lit("m3_first_wr_addr", addr_log[82], 15);
      lit("m3_second_rd_addr", addr_log[83], 14);
      lit("m3_last_wr_addr", addr_log[112], 0);
      lit("m4_first_rd_addr", addr_log[113], 15);
      lit("pass_fail_flag", int'(fail), 0);
      wait_cycles(2);

      // Start pulsed during M2 must be ignored
      launch(0);
      wait_cycles(59);
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(120);
      lit("done_cycle_restart_ignored", done_cyc, 177);
      wait_cycles(2);

      // Stuck-at-0 on bit 0 of word 5
      launch(1);
      wait_cycles(180);
      lit("fault_fail", int'(fail), 1);
      lit("fault_elem", int'(fail_elem), 2);
      lit("fault_addr", int'(fail_addr), 5);
      lit("fault_done_cycle", done_cyc, 177);
      wait_cycles(2);

      // Clean pass after a failing one: status clears on accept
      launch(0);
      wait_cycles(180);
      lit("clean_after_fault_fail", int'(fail), 0);
      lit("clean_after_fault_addr", int'(fail_addr), 0);
      wait_cycles(2);

      // Reset mid-M3, then a full pass
      launch(0);
      wait_cycles(89);
      rst = 1'b1;
      exp_q.delete();
      wait_cycles(1);
      rst = 1'b0;
      push_idle(0, 0, 0, 0);
      wait_cycles(1);
      launch(0);
      wait_cycles(180);
      lit("post_reset_done_cycle", done_cyc, 177);
      lit("post_reset_fail", int'(fail), 0);
      wait_cycles(3);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/march_bist_controller.md
# march_bist_controller

Sequencing FSM for the memory BIST datapath: runs a March C- test over an ARRAY_SIZE-word single-port synchronous RAM. It drives the up-counting address generator through its rst/en inputs and derives descending addresses by bit-inverting the count. It issues RAM reads and writes, compares read data against the expected background, and reports busy/done plus a sticky first-failure record.

## Interface
- ARRAY_SIZE, 16, number of RAM words; must be a power of two, at least 2
- ADDR_WIDTH, $clog2(ARRAY_SIZE), address width
- DATA_WIDTH, 8, RAM word width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request; accepted only in IDLE
- busy  out  1  test in progress
- done  out  1  test complete; sticky until next accepted start
- fail  out  1  at least one mismatch seen; sticky until next accepted start
- fail_addr  out  ADDR_WIDTH  mem_addr of first mismatch
- fail_elem  out  3  March element index (0..5) of first mismatch
- ag_rst  out  1  to address generator rst
- ag_en  out  1  to address generator en
- ag_addr  in  ADDR_WIDTH  address generator count
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; read latency exactly 1 cycle
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_re

## Operation
- Elements: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0). Background 0 is all-zeros, background 1 is all-ones.
- States: IDLE, RD, WR, DONE. Register elem[2:0] holds the current element.
- IDLE: ag_rst=1, so the counter is held at 0. When start=1: clear done, fail, fail_addr and fail_elem; set elem=0; go to WR.
- mem_addr = ag_addr for up elements; mem_addr = ~ag_addr for down elements (M3, M4).
- WR state:
  - mem_we=1, except in M5; mem_wdata = element's write background; ag_en=1.
  - For M1..M5, WR also compares the mem_rdata returned by the preceding RD.
  - A mismatch sets fail. If fail was 0, it also loads fail_addr=mem_addr and fail_elem=elem.
  - The test continues after a failure.
- RD state: mem_re=1, ag_en=0, go to WR.
- After WR:
  - If ag_addr != ARRAY_SIZE-1: M0 stays in WR; M1..M5 go to RD.
  - If ag_addr == ARRAY_SIZE-1: the counter wraps to 0 by itself, so no ag_rst is needed. elem increments and the next state is RD. After M5, the next state is DONE.
- DONE: done=1, ag_rst=1. Go to IDLE in the same cycle; done stays asserted in IDLE.
- start while busy is ignored.
- rst at any time: state=IDLE, elem=0, all status cleared. Any element in flight is abandoned.

## Timing
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, mem_we=0, mem_re=0, mem_wdata=0, mem_addr=0, ag_en=0, ag_rst=1.
- mem_*, ag_en and ag_rst are combinational from state, elem and ag_addr. busy is the decode "state is RD or WR". done, fail, fail_addr and fail_elem are registered.
- Cycle counts, with start sampled at edge 0:
  - First WR is cycle 1.
  - M0 takes N cycles; M1..M5 take 2N cycles each; total 11N active cycles.
  - busy is high for cycles 1..11N. DONE is cycle 11N+1, and done reads 1 from cycle 11N+1 on.
- Compare happens exactly one cycle after its mem_re. No read is ever outstanding across an element boundary or into DONE.

## Test plan
- Fault-free RAM model, N=16, start at cycle 0 -> busy on cycles 1..176; done=1 from cycle 177; fail=0; 16 writes of 0x00 in M0, then 80 reads and 64 writes.
- Bit 0 of word 5 stuck-at-0 -> fail=1, fail_elem=2, fail_addr=5, done still asserts at cycle 177.
- Monitor mem_addr during M3 and M4 -> sequence 15,15,14,14,...,0,0 (RD/WR pairs); up elements give 0..15.
- start pulsed again during M2 -> ignored; completion timing unchanged at cycle 177.
- rst asserted mid-M3 -> next cycle all outputs at reset values, ag_rst=1. A new start then runs a full 176-cycle pass with fail=0.
- Run with the fault, then a second start on a fault-free model -> done and fail clear on accept; second pass ends with fail=0 and fail_addr=0.
